matmul_sched: RTL and testbench

Round-robin scheduler that shares one `matmul_accel` instance (2×2 int8 matrix multiply, 32-bit packed operands, 128-bit packed result) between `NUM_REQ` requesters. It accepts one request at a time and drives the accelerator's `start`/`busy`/`done` handshake. It returns the result on a single valid/ready response channel tagged with the requester index, and flags a timeout if the accelerator never completes.

---
 rtl/matmul_pkg.sv | 23 ++
 rtl/matmul_sched_if.sv | 45 ++++
 rtl/matmul_accel.sv | 62 ++++++
 rtl/matmul_sched_rr_arbiter.sv | 39 +++
 rtl/matmul_sched.sv | 122 ++++++++++++
 tb/tb_matmul_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/matmul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : matmul_pkg                                                      |
// | Purpose  : Shared widths and scheduler state encoding for the matmul       |
// |            scheduler slice.                                                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package matmul_pkg;

  localparam int ELEM_W    = 8;    // int8 matrix element
  localparam int ACC_W     = 32;   // accumulated result element
  localparam int MAT_IN_W  = 32;   // packed 2x2 int8 operand
  localparam int MAT_OUT_W = 128;  // packed 2x2 int32 result

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/matmul_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : matmul_sched_if                                                 |
// | Purpose  : Request, response and accelerator handshake bundle of the       |
// |            matmul scheduler. slave = scheduler side, master = environment |
// |            (requesters, response consumer, accelerator).                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface matmul_sched_if
  import matmul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*MAT_IN_W-1:0] req_a;
  logic [NUM_REQ*MAT_IN_W-1:0] req_b;

  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [ID_W-1:0]             rsp_id;
  logic [MAT_OUT_W-1:0]        rsp_c;
  logic                        rsp_err;

  logic                        acc_start;
  logic [MAT_IN_W-1:0]         acc_a;
  logic [MAT_IN_W-1:0]         acc_b;
  logic                        acc_busy;
  logic                        acc_done;
  logic [MAT_OUT_W-1:0]        acc_c;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, acc_busy, acc_done, acc_c,
    output req_ready, rsp_valid, rsp_id, rsp_c, rsp_err, acc_start, acc_a, acc_b
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, acc_busy, acc_done, acc_c,
    input  req_ready, rsp_valid, rsp_id, rsp_c, rsp_err, acc_start, acc_a, acc_b
  );

endinterface
`default_nettype wire

// File: rtl/matmul_accel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : matmul_accel                                                    |
// | Purpose  : 2x2 int8 matrix multiply with fixed latency. start is taken    |
// |            when not busy; done pulses LATENCY cycles later with c valid.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module matmul_accel
  import matmul_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [MAT_IN_W-1:0]  a,
  input  logic [MAT_IN_W-1:0]  b,
  output logic                 busy,
  output logic                 done,
  output logic [MAT_OUT_W-1:0] c
);

  logic                 r_busy;
  logic [7:0]           r_cnt;
  logic [MAT_OUT_W-1:0] r_c;

  function automatic logic [ACC_W-1:0] sx(input logic [ELEM_W-1:0] e);
    return {{(ACC_W - ELEM_W){e[ELEM_W-1]}}, e};
  endfunction

  function automatic logic [MAT_OUT_W-1:0] mm(input logic [MAT_IN_W-1:0] x,
                                              input logic [MAT_IN_W-1:0] y);
    logic [ACC_W-1:0] x00, x01, x10, x11, y00, y01, y10, y11;
    x00 = sx(x[7:0]);   x01 = sx(x[15:8]);  x10 = sx(x[23:16]); x11 = sx(x[31:24]);
    y00 = sx(y[7:0]);   y01 = sx(y[15:8]);  y10 = sx(y[23:16]); y11 = sx(y[31:24]);
    return {x10 * y01 + x11 * y11, x10 * y00 + x11 * y10,
            x00 * y01 + x01 * y11, x00 * y00 + x01 * y10};
  endfunction

  // Latch the product at start, then count down the latency while busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_c    <= '0;
    end else if (start && !r_busy) begin
      r_busy <= 1'b1;
      r_cnt  <= 8'(LATENCY);
      r_c    <= mm(a, b);
    end else if (r_busy && r_cnt == 8'd1) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_cnt  <= r_cnt - 8'd1;
    end
  end

  assign busy = r_busy;
  assign done = r_busy && (r_cnt == 8'd1);
  assign c    = r_c;

endmodule
`default_nettype wire

// File: rtl/matmul_sched_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                      |
// | Purpose  : Combinational wrap-around priority pick starting at ptr.        |
// |            Produces a one-hot grant, its encoded index and an any flag.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] w_cand;

  // Scan from the farthest offset back to ptr so the nearest set bit wins last.
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    w_cand = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_cand = ID_W'((int'(ptr) + off) % NUM_REQ);
      if (req[w_cand]) begin
        grant         = '0;
        grant[w_cand] = 1'b1;
        idx           = w_cand;
        any           = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/matmul_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : matmul_sched                                                    |
// | Purpose  : Round-robin scheduler sharing one matmul accelerator between    |
// |            NUM_REQ requesters, with a tagged response channel and a WAIT   |
// |            timeout.                                                        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module matmul_sched
  import matmul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  matmul_sched_if.slave  bus
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  sched_state_t         r_state;
  sched_state_t         w_state_nxt;
  logic [ID_W-1:0]      r_ptr;
  logic [ID_W-1:0]      r_id;
  logic [ID_W-1:0]      w_win_idx;
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_win_any;
  logic [MAT_IN_W-1:0]  r_op_a;
  logic [MAT_IN_W-1:0]  r_op_b;
  logic [MAT_OUT_W-1:0] r_rsp_c;
  logic                 r_rsp_err;
  logic [TMR_W-1:0]     r_timer;
  logic                 w_expire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_win_idx),
    .any   (w_win_any)
  );

  // Timer holds the count of done-less WAIT cycles already seen, so this is
  // the TIMEOUT-th such cycle.
  assign w_expire = (r_timer == TMR_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; a done in the expiry cycle takes the normal path.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_win_any)        w_state_nxt = ISSUE;
      ISSUE:   if (!bus.acc_busy)    w_state_nxt = WAIT;
      WAIT:    if (bus.acc_done || w_expire) w_state_nxt = RESP;
      RESP:    if (bus.rsp_ready)    w_state_nxt = IDLE;
      default:                       w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, pointer advance, timer and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_id      <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_timer   <= '0;
      r_rsp_c   <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_win_any) begin
            r_op_a <= bus.req_a[int'(w_win_idx) * MAT_IN_W +: MAT_IN_W];
            r_op_b <= bus.req_b[int'(w_win_idx) * MAT_IN_W +: MAT_IN_W];
            r_id   <= w_win_idx;
            r_ptr  <= (w_win_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
          end
        end
        ISSUE: begin
          if (!bus.acc_busy) r_timer <= '0;
        end
        WAIT: begin
          if (bus.acc_done) begin
            r_rsp_c   <= bus.acc_c;
            r_rsp_err <= 1'b0;
          end else if (w_expire) begin
            r_rsp_c   <= '0;
            r_rsp_err <= 1'b1;
          end else begin
            r_timer   <= r_timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; grants are suppressed while reset is held.
  always_comb begin
    bus.req_ready = (r_state == IDLE && rst_n) ? w_grant : '0;
    bus.acc_start = (r_state == ISSUE) && !bus.acc_busy;
    bus.acc_a     = (r_state == ISSUE || r_state == WAIT) ? r_op_a : '0;
    bus.acc_b     = (r_state == ISSUE || r_state == WAIT) ? r_op_b : '0;
    bus.rsp_valid = (r_state == RESP);
    bus.rsp_id    = r_id;
    bus.rsp_c     = r_rsp_c;
    bus.rsp_err   = r_rsp_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_matmul_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_matmul_sched                                                 |
// | Purpose  : Scoreboard bench for matmul_sched with the real accelerator and |
// |            a never-done stub selectable at run time.                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_matmul_sched;
  import matmul_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 16;
  localparam int LAT     = 3;
  localparam logic [127:0] STUB_C = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [127:0]    c;
    logic            err;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  matmul_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

  matmul_sched #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic         acc_busy_r, acc_done_r;
  logic [127:0] acc_c_r;
  logic         stub_mode  = 1'b0;
  logic         stub_arm   = 1'b0;
  int           stub_delay = 0;
  int           t_start = 0, t_hs = 0, t_rsp = 0;

  matmul_accel #(.LATENCY(LAT)) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bus.acc_start & ~stub_mode),
    .a     (bus.acc_a),
    .b     (bus.acc_b),
    .busy  (acc_busy_r),
    .done  (acc_done_r),
    .c     (acc_c_r)
  );

  // Stub: never busy; done only when a nonzero delay is programmed.
  assign bus.acc_busy = stub_mode ? 1'b0 : acc_busy_r;
  assign bus.acc_done = stub_mode ? (stub_arm && stub_delay > 0 && cyc == t_start + stub_delay)
                                  : acc_done_r;
  assign bus.acc_c    = stub_mode ? STUB_C : acc_c_r;

  int   n_tests = 0, n_fail = 0;
  int   start_cnt = 0, r1_seen = 0, n_rsp = 0, rsp_rise = 0;
  logic rsp_valid_d = 1'b0;
  rsp_t sb_q[$];

  logic [31:0] a_tab[NUM_REQ][8];
  logic [31:0] b_tab[NUM_REQ][8];
  int          n_req[NUM_REQ];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mat(input logic [7:0] e00, input logic [7:0] e01,
                                      input logic [7:0] e10, input logic [7:0] e11);
    return {e11, e10, e01, e00};
  endfunction

  function automatic logic [127:0] pk(input int c00, input int c01, input int c10, input int c11);
    return {c11, c10, c01, c00};
  endfunction

  function automatic int el(input logic [31:0] m, input int i);
    logic signed [7:0] e;
    e = m[8*i +: 8];
    return int'(e);
  endfunction

  // Reference: C = A x B with row-major packing a00,a01,a10,a11 from LSB.
  function automatic logic [127:0] mm_ref(input logic [31:0] a, input logic [31:0] b);
    return pk(el(a,0)*el(b,0) + el(a,1)*el(b,2), el(a,0)*el(b,1) + el(a,1)*el(b,3),
              el(a,2)*el(b,0) + el(a,3)*el(b,2), el(a,2)*el(b,1) + el(a,3)*el(b,3));
  endfunction

  task automatic exp_push(input logic [ID_W-1:0] id, input logic [127:0] c, input logic err);
    rsp_t e;
    e.id = id; e.c = c; e.err = err;
    sb_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on each accepted response and records event cycles.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n) begin
      if (bus.acc_start) begin
        start_cnt++;
        t_start  = cyc;
        stub_arm = 1'b1;
      end
      if (|(bus.req_valid & bus.req_ready)) t_hs = cyc;
      if (bus.req_ready[1]) r1_seen++;
      if (bus.rsp_valid && !rsp_valid_d) begin
        t_rsp = cyc;
        rsp_rise++;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", 128'(bus.rsp_id), 128'hx);
        end else begin
          e = sb_q.pop_front();
          check("rsp_id",  128'(bus.rsp_id),  128'(e.id));
          check("rsp_c",   bus.rsp_c,         e.c);
          check("rsp_err", 128'(bus.rsp_err), 128'(e.err));
          n_rsp++;
        end
      end
    end else begin
      stub_arm = 1'b0;
    end
    rsp_valid_d = bus.rsp_valid;
  end

  // Presents the tabled requests; each requester holds until its handshake.
  task automatic run_reqs(input int budget);
    int          idx[NUM_REQ];
    logic [NUM_REQ-1:0] hs;
    int          cycles;
    bit          all_done;
    cycles = 0;
    foreach (idx[k]) idx[k] = 0;
    forever begin
      all_done = 1'b1;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (idx[k] < n_req[k]) begin
          bus.req_valid[k]        = 1'b1;
          bus.req_a[k*32 +: 32]   = a_tab[k][idx[k]];
          bus.req_b[k*32 +: 32]   = b_tab[k][idx[k]];
          all_done                = 1'b0;
        end else begin
          bus.req_valid[k] = 1'b0;
        end
      end
      if (all_done) break;
      if (cycles >= budget) begin
        check("req_handshake_timeout", 128'(cycles), 128'(budget - 1));
        bus.req_valid = '0;
        break;
      end
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      for (int k = 0; k < NUM_REQ; k++) if (hs[k]) idx[k]++;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic wait_drain(input int budget);
    int cycles;
    cycles = 0;
    while (sb_q.size() != 0 || bus.rsp_valid) begin
      if (cycles >= budget) begin
        check("drain_timeout", 128'(sb_q.size()), 128'd0);
        sb_q.delete();
        break;
      end
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rsp_valid"}, 128'(bus.rsp_valid), 128'd0);
    check({tag, "_rsp_id"},    128'(bus.rsp_id),    128'd0);
    check({tag, "_rsp_c"},     bus.rsp_c,           128'd0);
    check({tag, "_rsp_err"},   128'(bus.rsp_err),   128'd0);
    check({tag, "_acc_start"}, 128'(bus.acc_start), 128'd0);
    check({tag, "_acc_a"},     128'(bus.acc_a),     128'd0);
    check({tag, "_acc_b"},     128'(bus.acc_b),     128'd0);
    check({tag, "_req_ready"}, 128'(bus.req_ready), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s0;
    logic [127:0] ex0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    foreach (n_req[k]) n_req[k] = 0;

    // Reset state, with every requester valid to show the grant gating.
    rst_n         = 1'b0;
    bus.req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    bus.req_valid = '0;
    rst_n         = 1'b1;

    // 1: single request from requester 0.
    s0 = start_cnt;
    n_req = '{1, 0, 0, 0};
    a_tab[0][0] = mat(8'd1, 8'd2, 8'd3, 8'd4);
    b_tab[0][0] = mat(8'd5, 8'd6, 8'd7, 8'd8);
    exp_push(2'd0, pk(19, 22, 43, 50), 1'b0);
    run_reqs(50);
    wait_drain(50);
    check("t1_start_pulses", 128'(start_cnt - s0), 128'd1);

    // 2: signed operands, plus handshake->start and start->response latency.
    a_tab[0][0] = mat(8'hFF, 8'd2, 8'd3, 8'hFC);
    b_tab[0][0] = mat(8'd5, 8'hFA, 8'd7, 8'd8);
    exp_push(2'd0, pk(9, 22, -13, -50), 1'b0);
    run_reqs(50);
    wait_drain(50);
    check("t2_hs_to_start", 128'(t_start - t_hs), 128'd1);
    check("t2_start_to_rsp", 128'(t_rsp - t_start), 128'(LAT + 1));

    // 3: all requesters at once after reset; ids must come back in order.
    do_reset();
    n_req = '{1, 1, 1, 1};
    for (int k = 0; k < NUM_REQ; k++) begin
      a_tab[k][0] = mat(8'(k + 1), 8'd0, 8'd0, 8'(k + 1));
      b_tab[k][0] = mat(8'd1, 8'd2, 8'd3, 8'd4);
      exp_push(ID_W'(k), pk(k + 1, 2 * (k + 1), 3 * (k + 1), 4 * (k + 1)), 1'b0);
    end
    run_reqs(100);
    wait_drain(100);

    // 4: requesters 0 and 2 continuously valid; must alternate.
    do_reset();
    s0 = r1_seen;
    n_req = '{3, 0, 3, 0};
    for (int j = 0; j < 3; j++) begin
      a_tab[0][j] = $urandom(); b_tab[0][j] = $urandom();
      a_tab[2][j] = $urandom(); b_tab[2][j] = $urandom();
      exp_push(2'd0, mm_ref(a_tab[0][j], b_tab[0][j]), 1'b0);
      exp_push(2'd2, mm_ref(a_tab[2][j], b_tab[2][j]), 1'b0);
    end
    run_reqs(200);
    wait_drain(100);
    check("t4_req1_ready", 128'(r1_seen - s0), 128'd0);

    // 5: consumer stalls; response held, no new grant or start.
    bus.rsp_ready = 1'b0;
    n_req = '{1, 0, 0, 0};
    a_tab[0][0] = $urandom(); b_tab[0][0] = $urandom();
    ex0 = mm_ref(a_tab[0][0], b_tab[0][0]);
    exp_push(2'd0, ex0, 1'b0);
    run_reqs(50);
    for (int i = 0; i < 20 && !bus.rsp_valid; i++) begin
      @(posedge clk); #1;
    end
    a_tab[1][0] = $urandom(); b_tab[1][0] = $urandom();
    bus.req_valid[1]    = 1'b1;
    bus.req_a[32 +: 32] = a_tab[1][0];
    bus.req_b[32 +: 32] = b_tab[1][0];
    exp_push(2'd1, mm_ref(a_tab[1][0], b_tab[1][0]), 1'b0);
    repeat (10) begin
      @(negedge clk);
      check("t5_rsp_valid", 128'(bus.rsp_valid), 128'd1);
      check("t5_rsp_id",    128'(bus.rsp_id),    128'd0);
      check("t5_rsp_c",     bus.rsp_c,           ex0);
      check("t5_req_ready", 128'(bus.req_ready), 128'd0);
      check("t5_acc_start", 128'(bus.acc_start), 128'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    n_req = '{0, 1, 0, 0};
    run_reqs(50);
    wait_drain(50);

    // 6a: stub never completes -> timeout response.
    stub_mode  = 1'b1;
    stub_delay = 0;
    do_reset();
    n_req = '{1, 0, 0, 0};
    a_tab[0][0] = $urandom(); b_tab[0][0] = $urandom();
    exp_push(2'd0, 128'd0, 1'b1);
    run_reqs(50);
    wait_drain(60);
    check("t6a_timeout_latency", 128'(t_rsp - t_start), 128'(TIMEOUT + 1));

    // 6b: done lands in the expiry cycle and must win.
    stub_delay = TIMEOUT;
    do_reset();
    n_req = '{0, 0, 0, 1};
    a_tab[3][0] = $urandom(); b_tab[3][0] = $urandom();
    exp_push(2'd3, STUB_C, 1'b0);
    run_reqs(50);
    wait_drain(60);
    check("t6b_done_latency", 128'(t_rsp - t_start), 128'(TIMEOUT + 1));

    // 6c: reset during WAIT abandons the operation.
    stub_delay = 0;
    do_reset();
    n_req = '{1, 0, 0, 0};
    a_tab[0][0] = 32'h0102_0304; b_tab[0][0] = 32'h0506_0708;
    run_reqs(50);
    repeat (4) @(posedge clk);
    #1;
    s0 = rsp_rise;
    rst_n         = 1'b0;
    bus.req_valid = 4'b0100;
    @(posedge clk); #1;
    check_zero("t6c_reset");
    bus.req_valid = '0;
    rst_n         = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("t6c_no_rsp", 128'(rsp_rise - s0), 128'd0);
    check("t6c_sb_empty", 128'(sb_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
